// File: rtl/adv7393_cfg_sequencer.sv
// ADV7393 configuration sequencer: walks a register table and writes each entry over I2C with bounded retry.
// Optional read-back verification of every write is compiled in with `define ADV7393_CFG_READBACK_EN.
module adv7393_cfg_sequencer #(
  parameter int          NUM_REGS     = 16,
  parameter int          RESET_WAIT   = 1000,
  parameter int          MAX_RETRY    = 3,
  parameter logic [7:0]  I2C_DEV_ADDR = 8'h54,
  parameter int          AUTO_START   = 1,
  localparam int         IW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [IW-1:0] tbl_idx,
  input  logic [7:0]    tbl_addr,
  input  logic [7:0]    tbl_data,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic          cmd_rnw,
  output logic [7:0]    cmd_dev,
  output logic [7:0]    cmd_reg,
  output logic [7:0]    cmd_data,
  input  logic          rsp_valid,
  input  logic          rsp_nack,
  input  logic [7:0]    rsp_rdata,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [IW-1:0] err_idx
);

  localparam int WW = (RESET_WAIT > 0) ? $clog2(RESET_WAIT + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = (RESET_WAIT > 0) ? WW'(RESET_WAIT - 1) : '0;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_WAIT   = 4'd1,
    ST_ISSUE  = 4'd2,
    ST_RESP   = 4'd3,
`ifdef ADV7393_CFG_READBACK_EN
    ST_VISSUE = 4'd4,
    ST_VRESP  = 4'd5,
`endif
    ST_NEXT   = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERROR  = 4'd8
  } state_t;

`ifdef ADV7393_CFG_READBACK_EN
  localparam state_t ST_ACK = ST_VISSUE;
`else
  localparam state_t ST_ACK = ST_NEXT;
`endif

  state_t        state_r, state_nxt_s;
  logic [IW-1:0] idx_r, idx_nxt_s, err_idx_r, err_idx_nxt_s;
  logic [RW-1:0] retry_r, retry_nxt_s;
  logic [WW-1:0] wait_r, wait_nxt_s;
  logic [7:0]    cmd_reg_r, cmd_reg_nxt_s, cmd_data_r, cmd_data_nxt_s;
  logic [7:0]    wdata_r, wdata_nxt_s, cmd_dev_r;
  logic          last_r, last_nxt_s, auto_r;
  logic          cmd_valid_r, cmd_valid_nxt_s, cmd_rnw_r, cmd_rnw_nxt_s;
  logic          busy_r, busy_nxt_s, done_r, done_nxt_s, error_r, error_nxt_s;
  logic          idle_s, start_s, last_s, end_s, wait_done_s, can_retry_s;
  logic          resp_state_s, retry_inc_s;

  assign idle_s       = (state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR);
  assign start_s      = idle_s && (start || auto_r);
  assign last_s       = (idx_r == IW'(NUM_REGS - 1));
  assign end_s        = (tbl_addr == 8'hFF);
  assign wait_done_s  = (wait_r == WAIT_LAST);
  assign can_retry_s  = (retry_r < RW'(MAX_RETRY));
`ifdef ADV7393_CFG_READBACK_EN
  assign resp_state_s = (state_r == ST_RESP) || (state_r == ST_VRESP);
`else
  assign resp_state_s = (state_r == ST_RESP);
  logic unused_rdata_s;
  assign unused_rdata_s = ^{rsp_rdata, wdata_r};
`endif
  assign retry_inc_s  = resp_state_s && rsp_valid && (state_nxt_s == ST_ISSUE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; the end marker is checked while the index for the next ISSUE is already on tbl_idx
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (!start_s)             state_nxt_s = state_r;
        else if (RESET_WAIT > 0)  state_nxt_s = ST_WAIT;
        else if (end_s)           state_nxt_s = ST_DONE;
        else                      state_nxt_s = ST_ISSUE;
      end
      ST_WAIT: begin
        if (!wait_done_s) state_nxt_s = ST_WAIT;
        else if (end_s)   state_nxt_s = ST_DONE;
        else              state_nxt_s = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (cmd_ready) state_nxt_s = ST_RESP;
        else           state_nxt_s = ST_ISSUE;
      end
      ST_RESP: begin
        if (!rsp_valid)       state_nxt_s = ST_RESP;
        else if (!rsp_nack)   state_nxt_s = ST_ACK;
        else if (can_retry_s) state_nxt_s = ST_ISSUE;
        else                  state_nxt_s = ST_ERROR;
      end
`ifdef ADV7393_CFG_READBACK_EN
      ST_VISSUE: begin
        if (cmd_ready) state_nxt_s = ST_VRESP;
        else           state_nxt_s = ST_VISSUE;
      end
      ST_VRESP: begin
        if (!rsp_valid)                              state_nxt_s = ST_VRESP;
        else if (!rsp_nack && (rsp_rdata == wdata_r)) state_nxt_s = ST_NEXT;
        else if (can_retry_s)                        state_nxt_s = ST_ISSUE;
        else                                         state_nxt_s = ST_ERROR;
      end
`endif
      ST_NEXT: begin
        if (last_r || end_s) state_nxt_s = ST_DONE;
        else                 state_nxt_s = ST_ISSUE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output and datapath next values; index advances on NEXT entry so the table lookup is ready one cycle early
  always_comb begin
    idx_nxt_s       = idx_r;
    err_idx_nxt_s   = err_idx_r;
    retry_nxt_s     = retry_r;
    wait_nxt_s      = wait_r;
    last_nxt_s      = last_r;
    cmd_reg_nxt_s   = cmd_reg_r;
    cmd_data_nxt_s  = cmd_data_r;
    wdata_nxt_s     = wdata_r;
    cmd_valid_nxt_s = 1'b0;
    cmd_rnw_nxt_s   = 1'b0;
    busy_nxt_s      = 1'b1;
    done_nxt_s      = 1'b0;
    error_nxt_s     = 1'b0;
    case (state_nxt_s)
      ST_IDLE: busy_nxt_s = 1'b0;
      ST_ISSUE: begin
        cmd_valid_nxt_s = 1'b1;
        if (state_r != ST_ISSUE) begin
          cmd_reg_nxt_s  = tbl_addr;
          cmd_data_nxt_s = tbl_data;
          wdata_nxt_s    = tbl_data;
        end else begin
          cmd_reg_nxt_s  = cmd_reg_r;
        end
      end
`ifdef ADV7393_CFG_READBACK_EN
      ST_VISSUE: begin
        cmd_valid_nxt_s = 1'b1;
        cmd_rnw_nxt_s   = 1'b1;
        cmd_data_nxt_s  = 8'h00;
      end
`endif
      ST_NEXT: begin
        if (state_r != ST_NEXT) begin
          last_nxt_s  = last_s;
          retry_nxt_s = '0;
          idx_nxt_s   = last_s ? idx_r : idx_r + 1'b1;
        end else begin
          last_nxt_s  = last_r;
        end
      end
      ST_DONE: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b1;
        idx_nxt_s  = '0;
      end
      ST_ERROR: begin
        busy_nxt_s  = 1'b0;
        error_nxt_s = 1'b1;
        idx_nxt_s   = '0;
        if (state_r != ST_ERROR) err_idx_nxt_s = idx_r;
        else                     err_idx_nxt_s = err_idx_r;
      end
      default: busy_nxt_s = 1'b1;
    endcase
    if (start_s) begin
      idx_nxt_s   = '0;
      retry_nxt_s = '0;
      wait_nxt_s  = '0;
    end else if (state_r == ST_WAIT) begin
      wait_nxt_s  = wait_r + 1'b1;
    end else if (retry_inc_s) begin
      retry_nxt_s = retry_r + 1'b1;
    end else begin
      wait_nxt_s  = wait_r;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r       <= '0;
      err_idx_r   <= '0;
      retry_r     <= '0;
      wait_r      <= '0;
      last_r      <= 1'b0;
      cmd_reg_r   <= 8'h00;
      cmd_data_r  <= 8'h00;
      wdata_r     <= 8'h00;
      cmd_dev_r   <= I2C_DEV_ADDR;
      cmd_valid_r <= 1'b0;
      cmd_rnw_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      auto_r      <= (AUTO_START != 0);
    end else begin
      idx_r       <= idx_nxt_s;
      err_idx_r   <= err_idx_nxt_s;
      retry_r     <= retry_nxt_s;
      wait_r      <= wait_nxt_s;
      last_r      <= last_nxt_s;
      cmd_reg_r   <= cmd_reg_nxt_s;
      cmd_data_r  <= cmd_data_nxt_s;
      wdata_r     <= wdata_nxt_s;
      cmd_dev_r   <= I2C_DEV_ADDR;
      cmd_valid_r <= cmd_valid_nxt_s;
      cmd_rnw_r   <= cmd_rnw_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      error_r     <= error_nxt_s;
      auto_r      <= 1'b0;
    end
  end

  assign tbl_idx   = idx_r;
  assign err_idx   = err_idx_r;
  assign cmd_valid = cmd_valid_r;
  assign cmd_rnw   = cmd_rnw_r;
  assign cmd_dev   = cmd_dev_r;
  assign cmd_reg   = cmd_reg_r;
  assign cmd_data  = cmd_data_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule

// File: tb/tb_adv7393_cfg_sequencer.sv
// Bench for adv7393_cfg_sequencer: behavioural I2C master, fixed vector table, randomized runs vs a command-list model.
module tb_adv7393_cfg_sequencer;
  localparam int N  = 3;
  localparam int MR = 3;
`ifdef ADV7393_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] tbl_idx, err_idx;
  logic [7:0] tbl_addr, tbl_data, cmd_dev, cmd_reg, cmd_data, rsp_rdata;
  logic       cmd_valid, cmd_ready, cmd_rnw, rsp_valid, rsp_nack, busy, done, error;

  int total = 0;
  int bad   = 0;

  logic [7:0] ta [N];
  logic [7:0] td [N];
  assign tbl_addr = (int'(tbl_idx) < N) ? ta[tbl_idx] : 8'hFF;
  assign tbl_data = (int'(tbl_idx) < N) ? td[tbl_idx] : 8'h00;

  adv7393_cfg_sequencer #(.NUM_REGS(N), .RESET_WAIT(4), .MAX_RETRY(MR),
                          .I2C_DEV_ADDR(8'h54), .AUTO_START(1)) dut (
    .clk(clk), .reset(reset), .start(start), .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw), .cmd_dev(cmd_dev),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata), .busy(busy), .done(done),
    .error(error), .err_idx(err_idx));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // I2C master model state and per-entry plans
  int         lat = 2;
  int         pend = 0;
  logic       pend_nack;
  logic [7:0] pend_rdata;
  int         nack_left [N];
  int         corr_left [N];
  int         plan_nack [N];
  int         plan_corr [N];
  logic [7:0] mem [N];
  int         stall_idx = 0;
  int         stall_left = 0;
  logic [16:0] log_q [$];
  logic [16:0] exp_q [$];
  bit          exp_err;
  int          exp_eidx;

  initial begin
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_rdata = 8'h00;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      if (reset) begin
        pend = 0;
        cmd_ready = 1'b0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            rsp_valid = 1'b1; rsp_nack = pend_nack; rsp_rdata = pend_rdata;
          end
        end
        cmd_ready = 1'b1;
        if (cmd_valid && !cmd_rnw && stall_left > 0 && int'(tbl_idx) == stall_idx) begin
          cmd_ready = 1'b0;
          stall_left--;
          check("bp_hold", 32'({cmd_valid, cmd_reg, cmd_data}),
                32'({1'b1, ta[stall_idx], td[stall_idx]}));
        end
        if (cmd_valid && cmd_ready) begin
          int i;
          i = int'(tbl_idx);
          log_q.push_back({cmd_rnw, cmd_reg, cmd_data});
          pend = lat;
          pend_nack = 1'b0;
          pend_rdata = 8'h00;
          if (!cmd_rnw) begin
            if (nack_left[i] > 0) begin pend_nack = 1'b1; nack_left[i]--; end
            else mem[i] = cmd_data;
          end else if (corr_left[i] > 0) begin
            pend_rdata = mem[i] ^ 8'h01; corr_left[i]--;
          end else begin
            pend_rdata = mem[i];
          end
        end
      end
    end
  end

  // Reference: the ordered command list and outcome implied by table + nack/corrupt plans
  function automatic void build_expect();
    exp_q.delete();
    exp_err = 1'b0;
    exp_eidx = 0;
    for (int i = 0; i < N; i++) begin
      int nk = plan_nack[i];
      int cr = plan_corr[i];
      bit ok = 1'b0;
      if (ta[i] == 8'hFF) break;
      for (int a = 0; a <= MR; a++) begin
        exp_q.push_back({1'b0, ta[i], td[i]});
        if (nk > 0) begin nk--; continue; end
        if (RB) begin
          exp_q.push_back({1'b1, ta[i], 8'h00});
          if (cr > 0) begin cr--; continue; end
        end
        ok = 1'b1;
        break;
      end
      if (!ok) begin exp_err = 1'b1; exp_eidx = i; break; end
    end
  endfunction

  task automatic arm();
    for (int i = 0; i < N; i++) begin
      nack_left[i] = plan_nack[i];
      corr_left[i] = plan_corr[i];
    end
    log_q.delete();
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!((done || error) && !busy) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic compare_run(input string tag);
    bit same;
    check({tag, "_ncmd"}, 32'(log_q.size()), 32'(exp_q.size()));
    same = (log_q.size() == exp_q.size());
    for (int k = 0; k < exp_q.size() && same; k++)
      if (log_q[k] !== exp_q[k]) begin
        same = 1'b0;
        $display("  cmd %0d got %05h expected %05h", k, log_q[k], exp_q[k]);
      end
    check({tag, "_cmds"}, 32'(same), 32'd1);
    check({tag, "_flags"}, 32'({busy, done, error}), 32'({1'b0, !exp_err, exp_err}));
    if (exp_err) check({tag, "_err_idx"}, 32'(err_idx), 32'(exp_eidx));
  endtask

  task automatic run_seq(input string tag, input bit start_while_busy);
    int n = 0;
    build_expect();
    arm();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_start_clears"}, 32'({busy, done, error, tbl_idx}), 32'({3'b100, 2'd0}));
    if (start_while_busy) begin
      while (!cmd_valid && n < 100) begin @(negedge clk); n++; end
      check({tag, "_cmd_seen"}, 32'(cmd_valid), 32'd1);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    wait_end(tag);
    compare_run(tag);
  endtask

  task automatic default_table();
    ta[0] = 8'h00; td[0] = 8'h10;
    ta[1] = 8'h01; td[1] = 8'h20;
    ta[2] = 8'h02; td[2] = 8'h30;
    for (int i = 0; i < N; i++) begin plan_nack[i] = 0; plan_corr[i] = 0; end
    stall_left = 0;
    lat = 2;
  endtask

  typedef struct packed {
    logic [23:0] addrs;
    logic [23:0] datas;
    logic [11:0] nacks;
    logic [3:0]  stall1;
    logic        e_done;
    logic        e_err;
    logic [1:0]  e_eidx;
    logic [7:0]  e_ncmd;
  } vec_t;
  vec_t vecs [4];

  initial begin
    int n;
    vecs[0] = '{addrs:24'h020100, datas:24'h302010, nacks:12'h000, stall1:4'd5,
                e_done:1'b1, e_err:1'b0, e_eidx:2'd0, e_ncmd:(RB ? 8'd6 : 8'd3)};
    vecs[1] = '{addrs:24'h020100, datas:24'h302010, nacks:12'h020, stall1:4'd0,
                e_done:1'b1, e_err:1'b0, e_eidx:2'd0, e_ncmd:(RB ? 8'd8 : 8'd5)};
    vecs[2] = '{addrs:24'h020100, datas:24'h302010, nacks:12'hF00, stall1:4'd0,
                e_done:1'b0, e_err:1'b1, e_eidx:2'd2, e_ncmd:(RB ? 8'd8 : 8'd6)};
    vecs[3] = '{addrs:24'h02FF00, datas:24'h302010, nacks:12'h000, stall1:4'd0,
                e_done:1'b1, e_err:1'b0, e_eidx:2'd0, e_ncmd:(RB ? 8'd2 : 8'd1)};

    reset = 1'b1; start = 1'b0;
    default_table();
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({cmd_valid, cmd_rnw, busy, done, error, tbl_idx, err_idx, cmd_reg, cmd_data}), 32'd0);
    check("reset_dev", 32'(cmd_dev), 32'h54);

    // auto start: first command exactly 4 cycles after WAIT entry
    build_expect();
    arm();
    reset = 1'b0;
    n = 0;
    while (!busy && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (!cmd_valid && n < 50) begin @(negedge clk); n++; end
    check("auto_first_cmd_delay", 32'(n), 32'd4);
    check("auto_dev", 32'(cmd_dev), 32'h54);
    wait_end("auto");
    compare_run("auto");

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < N; i++) begin
        ta[i] = vecs[v].addrs[8*i +: 8];
        td[i] = vecs[v].datas[8*i +: 8];
        plan_nack[i] = int'(vecs[v].nacks[4*i +: 4]);
        plan_corr[i] = 0;
      end
      stall_idx = 1;
      stall_left = int'(vecs[v].stall1);
      lat = 2;
      run_seq($sformatf("vec%0d", v), 1'b0);
      check($sformatf("vec%0d_tbl_ncmd", v), 32'(log_q.size()), 32'(vecs[v].e_ncmd));
      check($sformatf("vec%0d_tbl_flags", v), 32'({done, error}), 32'({vecs[v].e_done, vecs[v].e_err}));
      if (vecs[v].e_err) check($sformatf("vec%0d_tbl_eidx", v), 32'(err_idx), 32'(vecs[v].e_eidx));
      if (vecs[v].stall1 != 4'd0) check($sformatf("vec%0d_stall_used", v), 32'(stall_left), 32'd0);
    end

    // end marker at entry 1 with a start pulse while entry 0 is in flight
    default_table();
    ta[1] = 8'hFF;
    run_seq("endmark_busy_start", 1'b1);
    check("endmark_ncmd", 32'(log_q.size()), RB ? 32'd2 : 32'd1);

`ifdef ADV7393_CFG_READBACK_EN
    default_table();
    plan_corr[0] = 1;
    run_seq("readback", 1'b0);
    check("readback_ncmd", 32'(log_q.size()), 32'd8);
`endif

    // reset while waiting for a response
    default_table();
    lat = 8;
    build_expect();
    arm();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (log_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    check("in_resp_no_valid", 32'({busy, cmd_valid}), 32'({1'b1, 1'b0}));
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outs", 32'({cmd_valid, cmd_rnw, busy, done, error, tbl_idx, err_idx, cmd_reg, cmd_data}), 32'd0);
    check("midreset_dev", 32'(cmd_dev), 32'h54);
    lat = 2;
    arm();
    @(negedge clk);
    reset = 1'b0;
    wait_end("post_reset");
    compare_run("post_reset");

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        ta[i] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        td[i] = 8'($urandom);
        plan_nack[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0;
        plan_corr[i] = RB ? int'($urandom_range(0, 1)) : 0;
      end
      lat = int'($urandom_range(1, 4));
      stall_idx = int'($urandom_range(0, 2));
      stall_left = int'($urandom_range(0, 3));
      run_seq($sformatf("rnd%0d", r), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adv7393_cfg_sequencer.md
Name: adv7393_cfg_sequencer

Overview:
Configuration sequencer for the ADV7393 video encoder. After reset, or on request, it walks a register table built from the regblock's ADV7393RegBlock_t. Each entry becomes an 8-bit register write issued to the I2C master through a valid/ready command channel. Each write completes on an ack/nack response, with bounded retry on nack. It reports busy/done/error to the top level and gates video enable until configuration completes.

Parameters:
NUM_REGS, 16, number of table entries (1..256)
RESET_WAIT, 1000, clk cycles between sequence start and first command; 0 = no wait
MAX_RETRY, 3, retries per entry after the first nack (total attempts = MAX_RETRY+1)
I2C_DEV_ADDR, 8'h54, ADV7393 8-bit write address driven on cmd_dev
AUTO_START, 1, 1 = sequence starts automatically when reset deasserts

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to run the sequence
tbl_idx  out  $clog2(NUM_REGS) (min 1)  current table index
tbl_addr  in  8  register address at tbl_idx; combinational, same cycle
tbl_data  in  8  register value at tbl_idx; combinational, same cycle
cmd_valid  out  1  command valid
cmd_ready  in  1  I2C master accepts command
cmd_rnw  out  1  1 = read, 0 = write
cmd_dev  out  8  I2C_DEV_ADDR
cmd_reg  out  8  register address
cmd_data  out  8  write data
rsp_valid  in  1  transaction complete, one-cycle pulse
rsp_nack  in  1  qualified by rsp_valid; 1 = nack
rsp_rdata  in  8  read data, qualified by rsp_valid
busy  out  1  sequence in progress
done  out  1  level; last sequence completed without error
error  out  1  level; last sequence aborted
err_idx  out  $clog2(NUM_REGS)  index of the failing entry

Behaviour:
- Reset state: every output 0, except cmd_dev = I2C_DEV_ADDR. Internal index, retry count and wait counter cleared. State = IDLE. If AUTO_START = 1, the first cycle after reset deasserts behaves as start.
- States: IDLE, WAIT, ISSUE, RESP, VISSUE, VRESP, NEXT, DONE, ERROR.
- Start handling:
  - start is accepted in IDLE, DONE or ERROR; it clears done, error, idx and retry, then goes to WAIT.
  - start is ignored while busy.
  - busy = 1 in every state except IDLE, DONE and ERROR.
- WAIT: count RESET_WAIT cycles, then ISSUE. With RESET_WAIT = 0, go directly to ISSUE.
- ISSUE:
  - If tbl_addr == 8'hFF (end marker), go to DONE with no command issued.
  - Otherwise assert cmd_valid with cmd_rnw = 0, cmd_reg = tbl_addr, cmd_data = tbl_data.
  - Fields are registered on entry to ISSUE and held stable until cmd_valid && cmd_ready; that cycle moves to RESP.
  - cmd_valid never drops before cmd_ready.
- RESP: wait for rsp_valid.
  - Ack: go to NEXT (or VISSUE when the macro is defined).
  - Nack with retry < MAX_RETRY: retry++ and return to ISSUE.
  - Nack with retry == MAX_RETRY: go to ERROR, err_idx = idx.
- NEXT:
  - idx == NUM_REGS-1: go to DONE.
  - Otherwise idx++, retry = 0, go to ISSUE.
  - idx never wraps.
- DONE: done = 1. ERROR: error = 1. Both hold until the next accepted start or reset.
- rsp_valid outside RESP/VRESP is ignored. cmd_ready outside ISSUE/VISSUE is ignored.
- No timeout. The I2C master must always return a response.
- Reset mid-transaction aborts immediately: cmd_valid is 0 from the next cycle. The I2C master shares the same reset.
- Minimum per-entry latency: 1 cycle in ISSUE, plus I2C master latency, plus 1 cycle in NEXT.

Optional Feature:
ADV7393_CFG_READBACK_EN
- Defined:
  - After a write ack, VISSUE issues a read of the same register (cmd_rnw = 1, cmd_data = 0).
  - VRESP handles the response:
    - Nack, or rsp_rdata != written value: counts as one failed attempt, retry++ and return to ISSUE (full rewrite). Same MAX_RETRY limit and ERROR path as a write nack.
    - Match: go to NEXT.
- Not defined: VISSUE and VRESP do not exist, cmd_rnw is tied to 0, and rsp_rdata is unused.

Test Plan:
- Auto start: AUTO_START = 1, RESET_WAIT = 4, NUM_REGS = 3, table {00:10, 01:20, 02:30}, master always acks with 2-cycle latency -> first cmd_valid exactly 4 cycles after WAIT entry; three writes (00/10, 01/20, 02/30) in order; done = 1, busy = 0, error = 0.
- Backpressure: cmd_ready held low 5 cycles on entry 1 -> cmd_valid, cmd_reg = 01 and cmd_data = 20 stay stable all 5 cycles; exactly one command is accepted.
- Retry: MAX_RETRY = 3, entry 1 nacks twice then acks -> 3 commands for entry 1, entry 2 follows, done = 1.
- Exhaustion: entry 2 always nacks -> exactly 4 attempts; error = 1, err_idx = 2, done = 0. A following start reruns from idx 0 with error cleared.
- End marker and start while busy: entry 1 address = FF -> only entry 0 is written, then done. A start pulse during entry 0 has no effect.
- Readback, macro on: entry 0 reads back 11 instead of 10 once -> write, read, rewrite, read, then NEXT. Reset asserted during RESP -> all outputs at reset values the following cycle.
